// File: rtl/rv_multicycle_seq.sv
// rv_multicycle_seq: RV32I multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Optional performance counters are built when RV_SEQ_PERF_COUNTERS_EN is defined.
`ifndef REG_SOURCE_MEMORY
`define REG_SOURCE_MEMORY 2'd1
`endif
module rv_multicycle_seq #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic        iwnIllegal,
  input  logic        iwDMemWrite,
  input  logic [1:0]  iwWriteRegSource,
  input  logic [4:0]  iwWriteReg,
  input  logic        iwMemAck,
  output logic        owMemReq,
  output logic        owMemWe,
  output logic        owMemIsFetch,
  output logic        owIrLoad,
  output logic        owPcWrite,
  output logic        owRegWrite,
  output logic        owRetire,
  output logic        owHalted,
  output logic        owBusError,
  output logic [2:0]  owState,
  output logic [31:0] owCycleCount,
  output logic [31:0] owRetireCount
);
  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;
  state_t state, nxt;
  logic [7:0] waitCnt;
  logic busErr, reqState, timeout;
  assign reqState = state == FETCH || state == MEM;
  // an ack arriving in the timeout cycle still completes the transfer
  assign timeout = reqState && !iwMemAck && waitCnt == 8'(MEM_TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      BOOT:    nxt = FETCH;
      FETCH:   nxt = iwMemAck ? DECODE : timeout ? HALT : FETCH;
      DECODE:  nxt = iwnIllegal ? EXEC : HALT;
      EXEC:    nxt = (iwDMemWrite || iwWriteRegSource == `REG_SOURCE_MEMORY) ? MEM : WB;
      MEM:     nxt = iwMemAck ? WB : timeout ? HALT : MEM;
      WB:      nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = BOOT;
    endcase
  end
  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      state   <= BOOT;
      waitCnt <= 8'd0;
      busErr  <= 1'b0;
    end else begin
      state   <= nxt;
      waitCnt <= (reqState && nxt == state) ? waitCnt + 8'd1 : 8'd0;
      busErr  <= busErr | timeout;
    end
  end
  assign owMemReq     = reqState;
  assign owMemIsFetch = state == FETCH;
  assign owMemWe      = state == MEM && iwDMemWrite;
  assign owIrLoad     = state == FETCH && iwMemAck;
  assign owPcWrite    = state == WB;
  assign owRetire     = state == WB;
  assign owRegWrite   = state == WB && iwWriteReg != 5'd0;
  assign owHalted     = state == HALT;
  assign owBusError   = busErr;
  assign owState      = state;
`ifdef RV_SEQ_PERF_COUNTERS_EN
  logic [31:0] cycleCnt, retireCnt;
  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      cycleCnt  <= 32'd0;
      retireCnt <= 32'd0;
    end else begin
      if (state != BOOT && state != HALT) cycleCnt <= cycleCnt + 32'd1;
      if (owRetire) retireCnt <= retireCnt + 32'd1;
    end
  end
  assign owCycleCount  = cycleCnt;
  assign owRetireCount = retireCnt;
`else
  assign owCycleCount  = 32'd0;
  assign owRetireCount = 32'd0;
`endif
endmodule

// File: tb/tb_rv_multicycle_seq.sv
// tb_rv_multicycle_seq: trace-model bench for rv_multicycle_seq with MEM_TIMEOUT=4.
`ifndef REG_SOURCE_MEMORY
`define REG_SOURCE_MEMORY 2'd1
`endif
module tb_rv_multicycle_seq;
  localparam int TO = 4;
`ifdef RV_SEQ_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic iwClk = 1'b0, iwRst = 1'b0, iwnIllegal = 1'b1, iwDMemWrite = 1'b0, iwMemAck = 1'b0;
  logic [1:0] iwWriteRegSource = 2'd0;
  logic [4:0] iwWriteReg = 5'd0;
  logic owMemReq, owMemWe, owMemIsFetch, owIrLoad, owPcWrite, owRegWrite, owRetire, owHalted, owBusError;
  logic [2:0] owState;
  logic [31:0] owCycleCount, owRetireCount;
  rv_multicycle_seq #(.MEM_TIMEOUT(TO)) dut (
    .iwClk(iwClk), .iwRst(iwRst), .iwnIllegal(iwnIllegal), .iwDMemWrite(iwDMemWrite),
    .iwWriteRegSource(iwWriteRegSource), .iwWriteReg(iwWriteReg), .iwMemAck(iwMemAck),
    .owMemReq(owMemReq), .owMemWe(owMemWe), .owMemIsFetch(owMemIsFetch), .owIrLoad(owIrLoad),
    .owPcWrite(owPcWrite), .owRegWrite(owRegWrite), .owRetire(owRetire), .owHalted(owHalted),
    .owBusError(owBusError), .owState(owState), .owCycleCount(owCycleCount), .owRetireCount(owRetireCount)
  );
  always #5 iwClk = ~iwClk;

  typedef struct {
    logic [2:0] st;
    logic       ack;
    logic       be;
  } ent_t;
  ent_t q[$];
  int total = 0, passed = 0;
  logic [31:0] mCyc = 32'd0, mRet = 32'd0;
  logic cDmw = 1'b0;
  logic [4:0] cRd = 5'd0;
  wire [11:0] obsOut = {owState, owMemReq, owMemWe, owMemIsFetch, owIrLoad, owPcWrite,
                        owRegWrite, owRetire, owHalted, owBusError};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // expected outputs for one cycle, straight from the state/output table
  function automatic logic [11:0] expOut(ent_t e);
    logic fe, me, wb;
    fe = e.st == 3'd1;
    me = e.st == 3'd4;
    wb = e.st == 3'd5;
    return {e.st, fe || me, me && cDmw, fe, fe && e.ack, wb, wb && cRd != 5'd0, wb,
            e.st == 3'd6, e.st == 3'd6 && e.be};
  endfunction

  task automatic push(input logic [2:0] st, input logic ack, input logic be);
    ent_t e;
    e.st = st; e.ack = ack; e.be = be;
    q.push_back(e);
  endtask

  task automatic haltTail(input logic be);
    for (int i = 0; i < 3; i++) push(3'd6, 1'($urandom_range(0, 1)), be);
  endtask

  task automatic reqPhase(input logic [2:0] st, input int w, output bit to);
    to = w >= TO;
    for (int i = 0; i < (to ? TO : w); i++) push(st, 1'b0, 1'b0);
    if (to) haltTail(1'b1);
    else push(st, 1'b1, 1'b0);
  endtask

  task automatic build(input bit boot, input int w1, input bit legal, input bit dmw,
                       input logic [1:0] src, input int w2);
    bit to;
    q.delete();
    if (boot) push(3'd0, 1'($urandom_range(0, 1)), 1'b0);
    reqPhase(3'd1, w1, to);
    if (to) return;
    push(3'd2, 1'($urandom_range(0, 1)), 1'b0);
    if (!legal) begin
      haltTail(1'b0);
      return;
    end
    push(3'd3, 1'($urandom_range(0, 1)), 1'b0);
    if (dmw || src == `REG_SOURCE_MEMORY) begin
      reqPhase(3'd4, w2, to);
      if (to) return;
    end
    push(3'd5, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic play(input string tag, input bit legal, input bit dmw,
                      input logic [1:0] src, input logic [4:0] rd);
    foreach (q[i]) begin
      @(negedge iwClk);
      if (i == 0) begin
        iwnIllegal = legal; iwDMemWrite = dmw; iwWriteRegSource = src; iwWriteReg = rd;
        cDmw = dmw; cRd = rd;
      end
      iwMemAck = q[i].ack;
      #1;
      chk($sformatf("%s[%0d].out", tag, i), 64'(obsOut), 64'(expOut(q[i])));
      chk($sformatf("%s[%0d].cnt", tag, i), {owCycleCount, owRetireCount},
          PERF ? {mCyc, mRet} : 64'd0);
      if (q[i].st != 3'd0 && q[i].st != 3'd6) mCyc++;
      if (q[i].st == 3'd5) mRet++;
    end
  endtask

  task automatic instr(input string tag, input bit boot, input int w1, input bit legal, input bit dmw,
                       input logic [1:0] src, input logic [4:0] rd, input int w2);
    build(boot, w1, legal, dmw, src, w2);
    play(tag, legal, dmw, src, rd);
  endtask

  // asserts reset away from any edge, checks the asynchronous drop, releases after an edge
  task automatic doReset(input string tag);
    iwRst = 1'b1;
    iwMemAck = 1'b0;
    #1;
    chk({tag, ".async"}, 64'(obsOut), 64'd0);
    chk({tag, ".cnt"}, {owCycleCount, owRetireCount}, 64'd0);
    @(posedge iwClk);
    #1;
    chk({tag, ".held"}, 64'(obsOut), 64'd0);
    iwRst = 1'b0;
    mCyc = 32'd0;
    mRet = 32'd0;
  endtask

  initial begin
    #1;
    doReset("reset");
    instr("addi", 1, 0, 1, 0, 2'd0, 5'd1, 0);
    instr("sw", 0, 0, 1, 1, 2'd0, 5'd0, 3);
    instr("lw", 0, 2, 1, 0, `REG_SOURCE_MEMORY, 5'd5, 1);
    instr("x0", 0, 3, 1, 0, 2'd2, 5'd0, 0);
    for (int n = 0; n < 30; n++)
      instr($sformatf("rnd%0d", n), 0, int'($urandom_range(0, 3)), 1, 1'($urandom),
            2'($urandom_range(0, 3)), 5'($urandom), int'($urandom_range(0, 3)));
`ifdef RV_SEQ_PERF_COUNTERS_EN
    force dut.cycleCnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycleCnt;
    mCyc = 32'hFFFF_FFFF;
    instr("wrap", 0, 0, 1, 0, 2'd0, 5'd2, 0);
`endif
    build(0, 0, 1, 1, 2'd0, 3);
    while (q.size() > 3) void'(q.pop_back());
    play("midmem", 1, 1, 2'd0, 5'd0);
    #2;
    doReset("midmemRst");
    instr("restart", 1, 0, 1, 0, 2'd0, 5'd3, 0);
    instr("illegal", 0, 1, 0, 0, 2'd0, 5'd4, 0);
    q.delete();
    for (int i = 0; i < 5; i++) push(3'd6, 1'($urandom_range(0, 1)), 1'b0);
    play("haltStick", 0, 0, 2'd0, 5'd4);
    doReset("illegalRst");
    instr("fetchTo", 1, TO, 1, 0, 2'd0, 5'd1, 0);
    doReset("fetchToRst");
    instr("memTo", 1, 0, 1, 1, 2'd0, 5'd0, TO);
    doReset("memToRst");
    instr("final", 1, 1, 1, 0, `REG_SOURCE_MEMORY, 5'd9, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
